// File: rtl/des_encryption_iterative.sv
// Iterative DES encryptor: one shared round per clock, 17 cycles per 64-bit block.
// Bit numbering follows FIPS 46-3 (bit 1 is the MSB) so the permutation tables read as published.
module des_encryption_iterative (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [1:64] PLAINTEXT,
  input  logic [1:64] KEY,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:64] CIPHERTEXT,
  output logic [1:56] KEY_OUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [1:48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_T [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Each box is stored row-major: entry index = row * 16 + column.
  localparam int SBOX [0:7][0:63] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:32] l_q, l_d, r_q, r_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [1:64] ct_q, ct_d;
  logic [1:56] key_out_q, key_out_d;

  logic [1:64] ip_out, fp_in, fp_out;
  logic [1:56] pc1_out, cd_rot;
  logic [1:28] c_rot, d_rot;
  logic [1:48] k_n, e_exp, e_x;
  logic [1:32] s_out, f_out;
  logic        one_shift, accept;
  logic        key_parity_unused;

  // Parity bits of the key play no part in the cipher.
  assign key_parity_unused = ^{KEY[8], KEY[16], KEY[24], KEY[32],
                               KEY[40], KEY[48], KEY[56], KEY[64]};

  for (genvar g = 1; g <= 64; g++) begin : g_ip_fp
    assign ip_out[g] = PLAINTEXT[IP_T[g]];
    assign fp_out[g] = fp_in[FP_T[g]];
  end

  for (genvar g = 1; g <= 56; g++) begin : g_pc1
    assign pc1_out[g] = KEY[PC1_T[g]];
  end

  // Shared round datapath: key schedule step, then f(R, Kn).
  assign one_shift = (cnt_q == 5'd1) || (cnt_q == 5'd2) || (cnt_q == 5'd9) || (cnt_q == 5'd16);
  assign c_rot     = one_shift ? {c_q[2:28], c_q[1]} : {c_q[3:28], c_q[1:2]};
  assign d_rot     = one_shift ? {d_q[2:28], d_q[1]} : {d_q[3:28], d_q[1:2]};
  assign cd_rot    = {c_rot, d_rot};

  for (genvar g = 1; g <= 48; g++) begin : g_pc2_e
    assign k_n[g]   = cd_rot[PC2_T[g]];
    assign e_exp[g] = r_q[E_T[g]];
  end

  assign e_x = e_exp ^ k_n;

  // Outer bits b1,b6 select the row, inner bits b2..b5 the column.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] sel;
    assign sel                = {e_x[6*j+1], e_x[6*j+6], e_x[6*j+2 +: 4]};
    assign s_out[4*j+1 +: 4]  = 4'(SBOX[j][sel]);
  end

  for (genvar g = 1; g <= 32; g++) begin : g_p
    assign f_out[g] = s_out[P_T[g]];
  end

  // Final swap: the output permutation sees R16 || L16.
  assign fp_in = {r_q, l_q};

  // A block is also accepted in FINISH so that a held START streams one block every 17 cycles.
  assign accept = START && ((state_q == IDLE) || (state_q == FINISH));

  always_comb begin
    // NOTE: every _d starts from its hold value, so no branch can leave a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    l_d       = l_q;
    r_d       = r_q;
    c_d       = c_q;
    d_d       = d_q;
    ct_d      = ct_q;
    key_out_d = key_out_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: ;
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_out;
        c_d = c_rot;
        d_d = d_rot;
        if (cnt_q == 5'd16) state_d = FINISH;
        else                cnt_d   = cnt_q + 5'd1;
      end
      FINISH: begin
        ct_d    = fp_out;
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      l_d       = ip_out[1:32];
      r_d       = ip_out[33:64];
      c_d       = pc1_out[1:28];
      d_d       = pc1_out[29:56];
      key_out_d = pc1_out;
      cnt_d     = 5'd1;
      state_d   = ROUND;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ct_q      <= '0;
      key_out_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      l_q       <= l_d;
      r_q       <= r_d;
      c_q       <= c_d;
      d_q       <= d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ct_q      <= ct_d;
      key_out_q <= key_out_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign CIPHERTEXT = ct_q;
  assign KEY_OUT    = key_out_q;

endmodule
